// File: rtl/latency_memory_pkg.sv
// Shared definitions for the latency_memory block.
//   rdw_mode_e       : same-address read-during-write policy
//   MAX_READ_LATENCY : upper bound on the configurable read pipeline depth
package latency_memory_pkg;

  typedef enum logic {
    READ_FIRST,
    WRITE_FIRST
  } rdw_mode_e;

  localparam int unsigned MAX_READ_LATENCY = 4;

endpackage

// File: rtl/latency_memory_read_pipe.sv
// Fixed-depth delay line for read results.
//   clk, rst   : clock and synchronous active-high clear of every stage
//   in_valid   : read accepted this cycle
//   in_data    : word sampled from the array this cycle
//   out_valid  : in_valid delayed by STAGES cycles
//   out_data   : in_data delayed by STAGES cycles
module mem_read_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d    = '0;
    data_d     = '0;
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int unsigned s = 1; s < STAGES; s++) begin
      valid_d[s] = valid_q[s-1];
      data_d[s]  = data_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    out_valid = valid_q[STAGES-1];
    out_data  = data_q[STAGES-1];
  end

endmodule

// File: rtl/latency_memory.sv
// Byte-strobed register-file memory with a fully pipelined, fixed-latency
// read port and a sticky out-of-range error flag.
//   clk, rst    : clock, synchronous active-high reset (clears the array too)
//   read_en     : read request, one accepted per cycle
//   read_addr   : read word address
//   read_data   : read result, zero whenever read_valid is low
//   read_valid  : read_en delayed by READ_LATENCY cycles
//   write_en    : write request
//   write_addr  : write word address
//   write_data  : write word
//   write_strb  : byte-lane enables, bit i covers write_data[8i+7:8i]
//   addr_err    : sticky, set by any out-of-range read or write
module latency_memory
  import latency_memory_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned READ_LATENCY = 2,
  parameter rdw_mode_e   RDW_MODE     = WRITE_FIRST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read_en,
  input  logic [$clog2(DEPTH)-1:0] read_addr,
  output logic [WIDTH-1:0]         read_data,
  output logic                     read_valid,
  input  logic                     write_en,
  input  logic [$clog2(DEPTH)-1:0] write_addr,
  input  logic [WIDTH-1:0]         write_data,
  input  logic [WIDTH/8-1:0]       write_strb,
  output logic                     addr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  if (READ_LATENCY == 0 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("latency_memory: READ_LATENCY must be in 1..%0d", MAX_READ_LATENCY);
  end
  if (WIDTH == 0 || (WIDTH % 8) != 0) begin : g_bad_width
    $error("latency_memory: WIDTH must be a non-zero multiple of 8");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             addr_err_q, addr_err_d;

  logic             rd_in_range, wr_in_range;
  logic             wr_any_strb, wr_active;
  logic [WIDTH-1:0] wr_mask, wr_merged, rd_word;
  logic             pipe_valid;
  logic [WIDTH-1:0] pipe_data;

  // Power-of-two depths cover the whole address space, so no range check.
  if ((DEPTH & (DEPTH - 1)) == 0) begin : g_full_range
    assign rd_in_range = 1'b1;
    assign wr_in_range = 1'b1;
  end else begin : g_partial_range
    assign rd_in_range = read_addr  < AW'(DEPTH);
    assign wr_in_range = write_addr < AW'(DEPTH);
  end

  always_comb begin
    wr_mask = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      wr_mask[b*8 +: 8] = {8{write_strb[b]}};
    end
    wr_any_strb = |write_strb;
    wr_active   = write_en && wr_any_strb && wr_in_range;
    wr_merged   = (mem_q[write_addr] & ~wr_mask) | (write_data & wr_mask);
  end

  // Word captured by the first pipe stage at the request edge; WRITE_FIRST
  // bypasses the strobe-merged write word on a same-address collision.
  always_comb begin
    rd_word = '0;
    if (read_en && rd_in_range) begin
      rd_word = mem_q[read_addr];
      if (RDW_MODE == WRITE_FIRST && wr_active && write_addr == read_addr) begin
        rd_word = (mem_q[read_addr] & ~wr_mask) | (write_data & wr_mask);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = (wr_active && write_addr == AW'(i)) ? wr_merged : mem_q[i];
    end
    // A zero-strobe write is a no-op and never flags an error.
    addr_err_d = addr_err_q
               | (read_en && !rd_in_range)
               | (write_en && wr_any_strb && !wr_in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      addr_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      addr_err_q <= addr_err_d;
    end
  end

  mem_read_pipe #(
    .WIDTH (WIDTH),
    .STAGES(READ_LATENCY)
  ) u_read_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (read_en),
    .in_data  (rd_word),
    .out_valid(pipe_valid),
    .out_data (pipe_data)
  );

  always_comb begin
    read_valid = pipe_valid;
    read_data  = pipe_valid ? pipe_data : '0;
    addr_err   = addr_err_q;
  end

endmodule

// File: tb/tb_latency_memory.sv
// Directed bench for latency_memory. Two instances share all inputs:
//   u_a : DEPTH=10, READ_LATENCY=2, WRITE_FIRST
//   u_b : DEPTH=10, READ_LATENCY=1, READ_FIRST
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so after tick() they reflect the edge just taken.
module tb_latency_memory;
  import latency_memory_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en;
  logic [3:0]  read_addr;
  logic        write_en;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_strb;

  logic [31:0] a_read_data, b_read_data;
  logic        a_read_valid, b_read_valid;
  logic        a_addr_err, b_addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  latency_memory #(
    .WIDTH(32), .DEPTH(10), .READ_LATENCY(2), .RDW_MODE(WRITE_FIRST)
  ) u_a (
    .clk(clk), .rst(rst), .read_en(read_en), .read_addr(read_addr),
    .read_data(a_read_data), .read_valid(a_read_valid),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .write_strb(write_strb), .addr_err(a_addr_err)
  );

  latency_memory #(
    .WIDTH(32), .DEPTH(10), .READ_LATENCY(1), .RDW_MODE(READ_FIRST)
  ) u_b (
    .clk(clk), .rst(rst), .read_en(read_en), .read_addr(read_addr),
    .read_data(b_read_data), .read_valid(b_read_valid),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .write_strb(write_strb), .addr_err(b_addr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Requests held high during reset must have no effect.
    rst = 1'b1; read_en = 1'b1; read_addr = 4'd5;
    write_en = 1'b1; write_addr = 4'd5; write_data = 32'hFFFF_FFFF; write_strb = 4'hF;
    tick(); tick();
    rst = 1'b0; read_en = 1'b0; write_en = 1'b0;
    n_checks++; if (a_read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %0b want 0", a_read_valid); end
    n_checks++; if (a_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_a_data: got %h want 0", a_read_data); end
    n_checks++; if (a_addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_a_err: got %0b want 0", a_addr_err); end
    n_checks++; if (b_read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: got %0b want 0", b_read_valid); end
    n_checks++; if (b_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_b_data: got %h want 0", b_read_data); end
    n_checks++; if (b_addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_b_err: got %0b want 0", b_addr_err); end
  endtask

  task automatic test_first_read();
    read_en = 1'b1; read_addr = 4'd5;
    tick();
    read_en = 1'b0;
    n_checks++; if (b_read_valid !== 1'b1) begin n_fail++; $display("FAIL first_b_valid: got %0b want 1", b_read_valid); end
    n_checks++; if (b_read_data !== 32'h0) begin n_fail++; $display("FAIL first_b_data: got %h want 0", b_read_data); end
    n_checks++; if (a_read_valid !== 1'b0) begin n_fail++; $display("FAIL first_a_early: got %0b want 0", a_read_valid); end
    tick();
    n_checks++; if (a_read_valid !== 1'b1) begin n_fail++; $display("FAIL first_a_valid: got %0b want 1", a_read_valid); end
    n_checks++; if (a_read_data !== 32'h0) begin n_fail++; $display("FAIL first_a_data: got %h want 0", a_read_data); end
    n_checks++; if (b_read_valid !== 1'b0) begin n_fail++; $display("FAIL first_b_drop: got %0b want 0", b_read_valid); end
  endtask

  task automatic test_strobe();
    write_en = 1'b1; write_addr = 4'd3; write_data = 32'hAABB_CCDD; write_strb = 4'b1111;
    tick();
    write_data = 32'h1122_3344; write_strb = 4'b0101;
    tick();
    // Zero-strobe write: memory and addr_err untouched.
    write_data = 32'h0; write_strb = 4'b0000;
    tick();
    write_en = 1'b0; read_en = 1'b1; read_addr = 4'd3;
    tick();
    read_en = 1'b0;
    n_checks++; if (b_read_data !== 32'hAA22_CC44) begin n_fail++; $display("FAIL strobe_b_data: got %h want aa22cc44", b_read_data); end
    tick();
    n_checks++; if (a_read_data !== 32'hAA22_CC44) begin n_fail++; $display("FAIL strobe_a_data: got %h want aa22cc44", a_read_data); end
    n_checks++; if (a_addr_err !== 1'b0) begin n_fail++; $display("FAIL strobe_zero_err: got %0b want 0", a_addr_err); end
  endtask

  task automatic test_back_to_back();
    write_en = 1'b1; write_strb = 4'hF;
    for (int k = 0; k < 8; k++) begin
      write_addr = 4'(k); write_data = 32'(100 + k);
      tick();
    end
    write_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_en = 1'b1; read_addr = 4'(i);
      tick();
      n_checks++; if (b_read_valid !== 1'b1 || b_read_data !== 32'(100 + i)) begin n_fail++; $display("FAIL b2b_b_%0d: got v=%0b d=%0d want v=1 d=%0d", i, b_read_valid, b_read_data, 100 + i); end
      if (i == 0) begin
        n_checks++; if (a_read_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_a_lead: got v=%0b want 0", a_read_valid); end
      end else begin
        n_checks++; if (a_read_valid !== 1'b1 || a_read_data !== 32'(99 + i)) begin n_fail++; $display("FAIL b2b_a_%0d: got v=%0b d=%0d want v=1 d=%0d", i - 1, a_read_valid, a_read_data, 99 + i); end
      end
    end
    read_en = 1'b0;
    tick();
    n_checks++; if (a_read_valid !== 1'b1 || a_read_data !== 32'd107) begin n_fail++; $display("FAIL b2b_a_7: got v=%0b d=%0d want v=1 d=107", a_read_valid, a_read_data); end
    n_checks++; if (b_read_valid !== 1'b0 || b_read_data !== 32'h0) begin n_fail++; $display("FAIL b2b_b_idle: got v=%0b d=%h want v=0 d=0", b_read_valid, b_read_data); end
  endtask

  task automatic test_inflight();
    read_en = 1'b1; read_addr = 4'd2;
    tick();
    // Overwrite the word while its read is still inside u_a's pipe.
    read_en = 1'b0; write_en = 1'b1; write_addr = 4'd2; write_data = 32'h0000_DEAD; write_strb = 4'hF;
    n_checks++; if (b_read_data !== 32'd102) begin n_fail++; $display("FAIL inflight_b: got %h want 102", b_read_data); end
    tick();
    write_en = 1'b0;
    n_checks++; if (a_read_valid !== 1'b1 || a_read_data !== 32'd102) begin n_fail++; $display("FAIL inflight_a: got v=%0b d=%0d want v=1 d=102", a_read_valid, a_read_data); end
  endtask

  task automatic test_rdw();
    write_en = 1'b1; write_addr = 4'd9; write_data = 32'h3; write_strb = 4'hF;
    tick();
    write_data = 32'h5; read_en = 1'b1; read_addr = 4'd9;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    n_checks++; if (b_read_data !== 32'h3) begin n_fail++; $display("FAIL rdw_read_first: got %h want 3", b_read_data); end
    tick();
    n_checks++; if (a_read_data !== 32'h5) begin n_fail++; $display("FAIL rdw_write_first: got %h want 5", a_read_data); end
    // Partial-strobe collision: bypass must be lane-merged.
    write_en = 1'b1; write_data = 32'hFFFF_FF00; write_strb = 4'b0110; read_en = 1'b1;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    n_checks++; if (b_read_data !== 32'h5) begin n_fail++; $display("FAIL rdw_rf_partial: got %h want 5", b_read_data); end
    tick();
    n_checks++; if (a_read_data !== 32'h00FF_FF05) begin n_fail++; $display("FAIL rdw_wf_partial: got %h want 00ffff05", a_read_data); end
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    n_checks++; if (b_read_data !== 32'h00FF_FF05) begin n_fail++; $display("FAIL rdw_after_b: got %h want 00ffff05", b_read_data); end
    tick();
    n_checks++; if (a_read_data !== 32'h00FF_FF05) begin n_fail++; $display("FAIL rdw_after_a: got %h want 00ffff05", a_read_data); end
  endtask

  task automatic test_oor_write();
    logic [31:0] exp_words [10];
    exp_words = '{32'd100, 32'd101, 32'h0000_DEAD, 32'd103, 32'd104,
                  32'd105, 32'd106, 32'd107, 32'h0, 32'h00FF_FF05};
    n_checks++; if (a_addr_err !== 1'b0 || b_addr_err !== 1'b0) begin n_fail++; $display("FAIL oorw_pre_err: got a=%0b b=%0b want 0", a_addr_err, b_addr_err); end
    write_en = 1'b1; write_addr = 4'd15; write_data = 32'hFFFF_FFFF; write_strb = 4'hF;
    tick();
    write_en = 1'b0;
    n_checks++; if (a_addr_err !== 1'b1 || b_addr_err !== 1'b1) begin n_fail++; $display("FAIL oorw_err: got a=%0b b=%0b want 1", a_addr_err, b_addr_err); end
    for (int i = 0; i < 10; i++) begin
      read_en = 1'b1; read_addr = 4'(i);
      tick();
      n_checks++; if (b_read_data !== exp_words[i]) begin n_fail++; $display("FAIL oorw_b_word%0d: got %h want %h", i, b_read_data, exp_words[i]); end
      if (i > 0) begin
        n_checks++; if (a_read_data !== exp_words[i-1]) begin n_fail++; $display("FAIL oorw_a_word%0d: got %h want %h", i - 1, a_read_data, exp_words[i-1]); end
      end
    end
    read_en = 1'b0;
    tick();
    n_checks++; if (a_read_data !== exp_words[9]) begin n_fail++; $display("FAIL oorw_a_word9: got %h want %h", a_read_data, exp_words[9]); end
    tick(); tick(); tick();
    n_checks++; if (a_addr_err !== 1'b1 || b_addr_err !== 1'b1) begin n_fail++; $display("FAIL oorw_sticky: got a=%0b b=%0b want 1", a_addr_err, b_addr_err); end
  endtask

  task automatic test_reset_flight();
    read_en = 1'b1; read_addr = 4'd4;
    tick();
    n_checks++; if (b_read_valid !== 1'b1 || b_read_data !== 32'd104) begin n_fail++; $display("FAIL flight_b_pre: got v=%0b d=%0d want v=1 d=104", b_read_valid, b_read_data); end
    rst = 1'b1; write_en = 1'b1; write_addr = 4'd4; write_data = 32'h0000_BEEF; write_strb = 4'hF;
    tick();
    n_checks++; if (a_read_valid !== 1'b0 || a_read_data !== 32'h0) begin n_fail++; $display("FAIL flight_a_drop: got v=%0b d=%h want v=0 d=0", a_read_valid, a_read_data); end
    n_checks++; if (b_read_valid !== 1'b0) begin n_fail++; $display("FAIL flight_b_drop: got %0b want 0", b_read_valid); end
    n_checks++; if (a_addr_err !== 1'b0 || b_addr_err !== 1'b0) begin n_fail++; $display("FAIL flight_err_clr: got a=%0b b=%0b want 0", a_addr_err, b_addr_err); end
    rst = 1'b0; read_en = 1'b0; write_en = 1'b0;
    tick();
    n_checks++; if (a_read_valid !== 1'b0) begin n_fail++; $display("FAIL flight_a_late: got %0b want 0", a_read_valid); end
    read_en = 1'b1; read_addr = 4'd4;
    tick();
    n_checks++; if (b_read_valid !== 1'b1 || b_read_data !== 32'h0) begin n_fail++; $display("FAIL flight_b_w4: got v=%0b d=%h want v=1 d=0", b_read_valid, b_read_data); end
    read_addr = 4'd9;
    tick();
    read_en = 1'b0;
    n_checks++; if (b_read_data !== 32'h0) begin n_fail++; $display("FAIL flight_b_w9: got %h want 0", b_read_data); end
    n_checks++; if (a_read_valid !== 1'b1 || a_read_data !== 32'h0) begin n_fail++; $display("FAIL flight_a_w4: got v=%0b d=%h want v=1 d=0", a_read_valid, a_read_data); end
    tick();
    n_checks++; if (a_read_valid !== 1'b1 || a_read_data !== 32'h0) begin n_fail++; $display("FAIL flight_a_w9: got v=%0b d=%h want v=1 d=0", a_read_valid, a_read_data); end
  endtask

  task automatic test_oor_read();
    n_checks++; if (a_addr_err !== 1'b0) begin n_fail++; $display("FAIL oorr_pre_err: got %0b want 0", a_addr_err); end
    read_en = 1'b1; read_addr = 4'd12;
    tick();
    read_en = 1'b0;
    n_checks++; if (b_read_valid !== 1'b1 || b_read_data !== 32'h0) begin n_fail++; $display("FAIL oorr_b: got v=%0b d=%h want v=1 d=0", b_read_valid, b_read_data); end
    n_checks++; if (a_addr_err !== 1'b1 || b_addr_err !== 1'b1) begin n_fail++; $display("FAIL oorr_err: got a=%0b b=%0b want 1", a_addr_err, b_addr_err); end
    tick();
    n_checks++; if (a_read_valid !== 1'b1 || a_read_data !== 32'h0) begin n_fail++; $display("FAIL oorr_a: got v=%0b d=%h want v=1 d=0", a_read_valid, a_read_data); end
    tick(); tick();
    n_checks++; if (a_addr_err !== 1'b1) begin n_fail++; $display("FAIL oorr_sticky: got %0b want 1", a_addr_err); end
  endtask

  initial begin
    rst = 1'b1; read_en = 1'b0; read_addr = '0;
    write_en = 1'b0; write_addr = '0; write_data = '0; write_strb = '0;
    test_reset();
    test_first_read();
    test_strobe();
    test_back_to_back();
    test_inflight();
    test_rdw();
    test_oor_write();
    test_reset_flight();
    test_oor_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/latency_memory.md
LATENCY_MEMORY -- requirements
Module: latency_memory

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 64, number of words; any value >= 2, need not be a power of two.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from accepted read to read_valid; legal range 1..4.
REQ-004 SHALL have parameter RDW_MODE, default WRITE_FIRST, same-address read-during-write policy: READ_FIRST or WRITE_FIRST.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 read_en  input  1  read request, accepted every cycle it is high.
REQ-008 read_addr  input  $clog2(DEPTH)  read word address.
REQ-009 read_data  output  WIDTH  read result, zero when read_valid low.
REQ-010 read_valid  output  1  read_data holds the result of the read issued READ_LATENCY cycles earlier.
REQ-011 write_en  input  1  write request.
REQ-012 write_addr  input  $clog2(DEPTH)  write word address.
REQ-013 write_data  input  WIDTH  write word.
REQ-014 write_strb  input  WIDTH/8  byte-lane enables; bit i covers write_data[8i+7:8i].
REQ-015 addr_err  output  1  sticky flag, set by any out-of-range read or write.

Function
REQ-016 Write: on a clock edge with write_en=1 and write_addr<DEPTH, each byte lane with strobe set SHALL be updated; lanes with strobe clear SHALL keep their value.
REQ-017 write_en=1 with write_strb all zero SHALL leave memory unchanged and SHALL NOT set addr_err.
REQ-018 Read: fully pipelined, one new read per cycle, no stalls; read issued at edge N SHALL present data and read_valid=1 during the cycle after edge N+READ_LATENCY-1 (READ_LATENCY=1: visible in the cycle after the request edge).
REQ-019 Array sampling SHALL occur at the request edge; later writes to that address SHALL NOT alter an in-flight result.
REQ-020 Same-edge read and write to same in-range address: WRITE_FIRST SHALL return the post-write word (strobe-merged); READ_FIRST SHALL return the pre-write word.
REQ-021 Out-of-range address (addr >= DEPTH): read SHALL return zero with read_valid still asserted on schedule; write SHALL be ignored; both SHALL set addr_err.
REQ-022 addr_err SHALL stay 1 until rst.
REQ-023 read_valid SHALL be a pure delayed copy of read_en; back-to-back reads SHALL give back-to-back valids with no bubbles.
REQ-024 read_data SHALL be forced to zero whenever read_valid=0.

Reset
REQ-025 While rst=1 at an edge: all memory words SHALL clear to 0, every pipeline stage SHALL invalidate, addr_err SHALL clear.
REQ-026 Outputs after reset edge: read_data=0, read_valid=0, addr_err=0.
REQ-027 Reads in flight when rst asserts SHALL be discarded, never producing read_valid.
REQ-028 read_en/write_en sampled during rst SHALL have no effect.

Structure
REQ-029 Package latency_memory_pkg SHALL hold the rdw_mode_e enum (READ_FIRST, WRITE_FIRST) and MAX_READ_LATENCY=4.
REQ-030 Read delay SHALL be a sub-module mem_read_pipe (parameters WIDTH, STAGES) carrying {valid, data} through STAGES registers with synchronous clear.
REQ-031 Elaboration SHALL fail for READ_LATENCY outside 1..4 or WIDTH not a multiple of 8.

Verification
REQ-032 Reset then read addr 5, READ_LATENCY=2 -> read_valid=1 exactly 2 cycles later with read_data=0.
REQ-033 WIDTH=32: write 0xAABBCCDD strb 1111 to addr 3, then write 0x11223344 strb 0101 -> read addr 3 returns 0xAA22CC44.
REQ-034 Reads addr 0..7 on 8 consecutive cycles after filling word k = k+100 -> 8 consecutive valids, data 100..107, in order.
REQ-035 Same-edge write 0x5 and read addr 9 (old 0x3) -> WRITE_FIRST returns 0x5, READ_FIRST returns 0x3.
REQ-036 DEPTH=10: read addr 12 -> read_data=0 with read_valid on schedule, addr_err=1 until rst; write addr 15 leaves all words unchanged.
REQ-037 Issue reads, assert rst one cycle later -> no read_valid emerges; memory reads back 0 afterwards.
